// File: rtl/jtag_cfg_deser.sv
// Deserialises the tile's serial configuration stream (MSB first) into
// WORD_W-bit words and writes them at incrementing addresses into the config RAM.
module jtag_cfg_deser #(
   parameter int WORD_W    = 16,
   parameter int NUM_WORDS = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic              cfg_we,
   output logic [ADDR_W-1:0] cfg_addr,
   output logic [WORD_W-1:0] cfg_wdata,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam int BIT_CNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int WORD_CNT_W = ADDR_W + 1;
   localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(WORD_W - 1);
   localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state, state_next;
   logic [WORD_W-1:0]     shreg, shreg_next;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic [WORD_CNT_W-1:0] word_cnt;
   logic                  accept, word_end, last_word;

   always_comb begin
      accept     = bit_valid && (state != DONE);
      word_end   = accept && (bit_cnt == LAST_BIT);
      last_word  = word_end && (word_cnt == LAST_WORD);
      shreg_next = {shreg[WORD_W-2:0], bit_in};
      state_next = state;
      if (restart)
         state_next = IDLE;
      else if (last_word)
         state_next = DONE;
      else if (accept)
         state_next = SHIFT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Write strobe, address and data are registered so the RAM sees a clean
   // one-cycle pulse; address/data simply hold between writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         word_cnt  <= '0;
         cfg_we    <= 1'b0;
         cfg_addr  <= '0;
         cfg_wdata <= '0;
         overrun   <= 1'b0;
      end else begin
         cfg_we <= 1'b0;
         if (restart) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            overrun  <= 1'b0;
         end else if (accept) begin
            shreg <= shreg_next;
            if (word_end) begin
               cfg_we    <= 1'b1;
               cfg_wdata <= shreg_next;
               cfg_addr  <= word_cnt[ADDR_W-1:0];
               bit_cnt   <= '0;
               word_cnt  <= word_cnt + 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end else if (bit_valid && (state == DONE)) begin
            overrun <= 1'b1;
         end
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_jtag_cfg_deser.sv
// Directed self-checking bench for jtag_cfg_deser: table of single words plus
// hand-written full-load, overrun/restart and mid-word reset sequences.
module tb_jtag_cfg_deser;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        restart = 1'b0;
   logic        bit_in = 1'b0;
   logic        bit_valid = 1'b0;
   logic        cfg_we;
   logic [7:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        busy, done, overrun;

   int compared = 0;
   int mismatched = 0;

   jtag_cfg_deser #(.WORD_W(16), .NUM_WORDS(256), .ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .restart(restart), .bit_in(bit_in), .bit_valid(bit_valid),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        do_reset;
      logic        gapped;
      logic [15:0] word;
      logic [7:0]  exp_addr;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[4];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      bit_valid = 1'b0;
      restart   = 1'b0;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Streams one word MSB first; returns counts of stray strobes and of
   // cycles where busy was low before the final bit.
   task automatic apply_stimulus(input logic [15:0] word, input logic gapped,
                                 output int early_we, output int busy_low);
      early_we = 0;
      busy_low = 0;
      for (int i = 15; i >= 0; i--) begin
         bit_valid = 1'b1;
         bit_in    = word[i];
         @(posedge clk); #1;
         if (i != 0) begin
            if (cfg_we) early_we++;
            if (!busy) busy_low++;
            if (gapped) begin
               bit_valid = 1'b0;
               @(posedge clk); #1;
               if (cfg_we) early_we++;
               if (!busy) busy_low++;
            end
         end
      end
   endtask

   task automatic check_word(input logic [7:0] exp_addr, input logic [15:0] exp_data,
                             input logic exp_busy, input logic exp_done,
                             input int early_we, input int busy_low);
      check_output("we_pulse", 32'(cfg_we), 32'd1);
      check_output("addr", 32'(cfg_addr), 32'(exp_addr));
      check_output("wdata", 32'(cfg_wdata), 32'(exp_data));
      check_output("busy_at_write", 32'(busy), 32'(exp_busy));
      check_output("done_at_write", 32'(done), 32'(exp_done));
      check_output("early_we", 32'(early_we), 32'd0);
      check_output("busy_in_word", 32'(busy_low), 32'd0);
   endtask

   initial begin
      int early, blow, stray;

      vecs[0] = '{do_reset: 1'b1, gapped: 1'b0, word: 16'hA5C3, exp_addr: 8'd0, exp_data: 16'hA5C3};
      vecs[1] = '{do_reset: 1'b1, gapped: 1'b1, word: 16'hA5C3, exp_addr: 8'd0, exp_data: 16'hA5C3};
      vecs[2] = '{do_reset: 1'b0, gapped: 1'b1, word: 16'h0001, exp_addr: 8'd1, exp_data: 16'h0001};
      vecs[3] = '{do_reset: 1'b0, gapped: 1'b0, word: 16'h8000, exp_addr: 8'd2, exp_data: 16'h8000};

      // Reset then idle: everything stays zero.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check_output("idle_outputs", {5'd0, cfg_we, cfg_addr, cfg_wdata, busy, done, overrun}, 32'd0);
      end

      // Single words, ungapped and gapped, each followed by a hold cycle.
      for (int v = 0; v < 4; v++) begin
         if (vecs[v].do_reset) do_reset();
         apply_stimulus(vecs[v].word, vecs[v].gapped, early, blow);
         check_word(vecs[v].exp_addr, vecs[v].exp_data, 1'b1, 1'b0, early, blow);
         bit_valid = 1'b0;
         @(posedge clk); #1;
         check_output("we_single_cycle", 32'(cfg_we), 32'd0);
         check_output("wdata_hold", 32'(cfg_wdata), 32'(vecs[v].exp_data));
         check_output("addr_hold", 32'(cfg_addr), 32'(vecs[v].exp_addr));
      end

      // Full load of 256 back-to-back words.
      do_reset();
      for (int k = 0; k < 256; k++) begin
         apply_stimulus(16'(k) ^ 16'h5A5A, 1'b0, early, blow);
         check_word(8'(k), 16'(k) ^ 16'h5A5A, (k != 255), (k == 255), early, blow);
      end
      bit_valid = 1'b0;
      stray = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (cfg_we) stray++;
      end
      check_output("no_write_after_done", 32'(stray), 32'd0);
      check_output("done_sticky", 32'(done), 32'd1);
      check_output("no_overrun_yet", 32'(overrun), 32'd0);

      // Overrun: extra bits after DONE are flagged but never written.
      for (int c = 0; c < 3; c++) begin
         bit_valid = 1'b1;
         bit_in    = 1'b1;
         @(posedge clk); #1;
         check_output("overrun_no_we", 32'(cfg_we), 32'd0);
         check_output("overrun_flag", 32'(overrun), 32'd1);
         check_output("overrun_addr", 32'(cfg_addr), 32'd255);
      end

      // Restart wins over a simultaneous valid bit.
      restart = 1'b1;
      @(posedge clk); #1;
      restart   = 1'b0;
      bit_valid = 1'b0;
      check_output("restart_done", 32'(done), 32'd0);
      check_output("restart_overrun", 32'(overrun), 32'd0);
      check_output("restart_busy", 32'(busy), 32'd0);
      check_output("restart_we", 32'(cfg_we), 32'd0);
      apply_stimulus(16'hBEEF, 1'b0, early, blow);
      check_word(8'd0, 16'hBEEF, 1'b1, 1'b0, early, blow);

      // Reset mid-word: partial word of word 2 is dropped.
      for (int c = 0; c < 7; c++) begin
         bit_valid = 1'b1;
         bit_in    = 1'b1;
         @(posedge clk); #1;
      end
      bit_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_output("async_rst_busy", 32'(busy), 32'd0);
      check_output("async_rst_addr", 32'(cfg_addr), 32'd0);
      check_output("async_rst_wdata", 32'(cfg_wdata), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_output("rst_no_we", 32'(cfg_we), 32'd0);
      apply_stimulus(16'h1234, 1'b0, early, blow);
      check_word(8'd0, 16'h1234, 1'b1, 1'b0, early, blow);
      bit_valid = 1'b0;
      @(posedge clk); #1;
      check_output("final_we_low", 32'(cfg_we), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
